// File: rtl/shift_pkg.sv
// Shared sizing constants and output-buffer state encoding for the serial deserializer.
package shift_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int CNT_W     = 7;
  localparam int WCNT_W    = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;
endpackage

// File: rtl/shift_deser_obuf.sv
// Single-entry output register with valid/ready handshake; flags a load it cannot take.
module shift_deser_obuf
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             drop
);
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_hs;
  logic             w_take;

  // A load is accepted when empty or when the held word leaves on this same edge.
  assign w_hs   = (r_state == ST_FULL) && ready;
  assign w_take = load && ((r_state == ST_IDLE) || w_hs);
  assign drop   = load && !w_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_count <= '0;
    end else if (w_take) begin
      r_state <= ST_FULL;
      r_data  <= load_data;
      r_count <= load_count;
    end else if (w_hs) begin
      r_state <= ST_IDLE;
    end
  end

  assign valid = (r_state == ST_FULL);
  assign data  = r_data;
  assign count = r_count;
endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: bit accumulator with flush, buffered word output,
// sticky overflow on dropped words and an accepted-word counter.
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              shift_din,
  input  logic              flush,
  input  logic              clear_overflow,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              overflow,
  output logic [WCNT_W-1:0] word_cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]  r_acc;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_overflow;
  logic [WCNT_W-1:0] r_word_cnt;

  logic [WIDTH-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_complete;
  logic              w_load;
  logic              w_drop;
  logic              w_valid;
  logic              w_hs;

  always_comb begin
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_bit_cnt;
    if (enable) begin
      if (MSB_FIRST) w_acc_nxt = {r_acc[WIDTH-2:0], shift_din};
      else           w_acc_nxt = {shift_din, r_acc[WIDTH-1:1]};
      w_cnt_nxt = r_bit_cnt + 1'b1;
    end
  end

  // The accumulator starts each word at zero, so unreceived positions already read 0.
  assign w_complete = enable && (r_bit_cnt == LAST);
  assign w_load     = w_complete || (flush && (w_cnt_nxt != '0));

  always_ff @(posedge clk) begin
    if (reset || w_load) begin
      r_acc     <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_bit_cnt <= w_cnt_nxt;
    end
  end

  shift_deser_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_data  (w_acc_nxt),
    .load_count (w_cnt_nxt),
    .ready      (out_ready),
    .valid      (w_valid),
    .data       (out_data),
    .count      (out_count),
    .drop       (w_drop)
  );

  assign w_hs = w_valid && out_ready;

  // A new drop wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
      if (w_hs) r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  assign out_valid = w_valid;
  assign overflow  = r_overflow;
  assign word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_shift_deser.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; a bit-list model
// predicts each emitted word, and a negedge monitor checks every handshake.
module tb_shift_deser;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, shift_din = 1'b0, flush = 1'b0;
  logic clear_overflow = 1'b0, out_ready = 1'b0;

  logic         v  [2];
  logic [W-1:0] d  [2];
  logic [6:0]   c  [2];
  logic         o  [2];
  logic [31:0]  wc [2];

  always #5 clk = ~clk;

  shift_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .enable(enable), .shift_din(shift_din), .flush(flush),
    .clear_overflow(clear_overflow), .out_ready(out_ready),
    .out_valid(v[0]), .out_data(d[0]), .out_count(c[0]), .overflow(o[0]), .word_cnt(wc[0]));

  shift_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .enable(enable), .shift_din(shift_din), .flush(flush),
    .clear_overflow(clear_overflow), .out_ready(out_ready),
    .out_valid(v[1]), .out_data(d[1]), .out_count(c[1]), .overflow(o[1]), .word_cnt(wc[1]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: received bits kept as a list, words built from the list on emit.
  bit          m_bits[$];
  exp_t        q0[$], q1[$];
  logic        cur_valid = 1'b0, nxt_valid = 1'b0;
  logic        cur_ovf = 1'b0, nxt_ovf = 1'b0;
  logic [31:0] cur_wcnt = '0, nxt_wcnt = '0;
  bit          mon_en = 1'b0;
  int          vcnt0 = 0;
  logic [W-1:0] last_d0 = '0, last_d1 = '0;
  int          last_c0 = 0, last_c1 = 0;

  function automatic logic [W-1:0] build(input bit msb);
    logic [W-1:0] w = '0;
    int n = m_bits.size();
    for (int i = 0; i < n; i++) begin
      if (msb) w[n-1-i] = m_bits[i];
      else     w[W-n+i] = m_bits[i];
    end
    return w;
  endfunction

  task automatic step(input logic rst, input logic en, input logic din,
                      input logic fl, input logic clr, input logic rdy);
    bit hs, ld, drop;
    exp_t e;
    @(posedge clk);
    cur_valid = nxt_valid;
    cur_ovf   = nxt_ovf;
    cur_wcnt  = nxt_wcnt;
    #1;
    reset = rst; enable = en; shift_din = din; flush = fl;
    clear_overflow = clr; out_ready = rdy;
    if (rst) begin
      m_bits.delete(); q0.delete(); q1.delete();
      nxt_valid = 1'b0; nxt_ovf = 1'b0; nxt_wcnt = '0;
    end else begin
      hs   = cur_valid && rdy;
      drop = 1'b0;
      if (en) m_bits.push_back(din);
      ld = (m_bits.size() == W) || (fl && m_bits.size() > 0);
      nxt_valid = hs ? 1'b0 : cur_valid;
      nxt_wcnt  = hs ? cur_wcnt + 1 : cur_wcnt;
      if (ld) begin
        if (!cur_valid || hs) begin
          e.c = m_bits.size();
          e.d = build(1'b1); q0.push_back(e);
          e.d = build(1'b0); q1.push_back(e);
          nxt_valid = 1'b1;
        end else begin
          drop = 1'b1;
        end
        m_bits.delete();
      end
      nxt_ovf = drop ? 1'b1 : (clr ? 1'b0 : cur_ovf);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    exp_t e0, e1;
    if (mon_en) begin
      chk("valid_msb", 64'(v[0]), 64'(cur_valid));
      chk("valid_lsb", 64'(v[1]), 64'(cur_valid));
      chk("ovf_msb", 64'(o[0]), 64'(cur_ovf));
      chk("ovf_lsb", 64'(o[1]), 64'(cur_ovf));
      chk("wcnt_msb", 64'(wc[0]), 64'(cur_wcnt));
      chk("wcnt_lsb", 64'(wc[1]), 64'(cur_wcnt));
      if (v[0]) vcnt0++;
      if (!reset && out_ready) begin
        if (v[0]) begin
          if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL word_msb unexpected got=%h want=none", d[0]);
          end else begin
            e0 = q0.pop_front();
            chk("data_msb", d[0], e0.d);
            chk("count_msb", 64'(c[0]), 64'(e0.c));
          end
          last_d0 = d[0]; last_c0 = int'(c[0]);
        end
        if (v[1]) begin
          if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL word_lsb unexpected got=%h want=none", d[1]);
          end else begin
            e1 = q1.pop_front();
            chk("data_lsb", d[1], e1.d);
            chk("count_lsb", 64'(c[1]), 64'(e1.c));
          end
          last_d1 = d[1]; last_c1 = int'(c[1]);
        end
      end
    end
  end

  initial begin
    logic [63:0] pat;
    logic [63:0] expw;
    logic        b;
    logic [4:0]  s3;

    step(1'b1, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    look();
    chk("rst_data", d[0], '0);
    chk("rst_count", 64'(c[0]), 64'd0);

    // 1: full MSB-first word with ready held high
    vcnt0 = 0;
    pat = 64'hDEADBEEF_01234567;
    for (int i = 63; i >= 0; i--) step(1'b0, 1'b1, pat[i], 0, 0, 1'b1);
    idle(3, 1'b1);
    look();
    chk("s1_data", last_d0, 64'hDEADBEEF_01234567);
    chk("s1_count", 64'(last_c0), 64'd64);
    chk("s1_vcycles", 64'(vcnt0), 64'd1);
    chk("s1_wcnt", 64'(wc[0]), 64'd1);

    // 2: LSB-first, enable every other cycle, garbage on idle cycles
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 128; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, (i == 0), 0, 0, 1'b1);
      else            step(1'b0, 1'b0, 1'($urandom), 0, 0, 1'b1);
    end
    idle(2, 1'b1);
    look();
    chk("s2_data", last_d1, 64'h0000_0000_0000_0001);

    // 3: partial word flushed with enable low, then a full word
    step(1'b1, 0, 0, 0, 0, 0);
    s3 = 5'b10110;
    for (int i = 4; i >= 0; i--) step(1'b0, 1'b1, s3[i], 0, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    idle(2, 1'b1);
    look();
    chk("s3_data", last_d0, 64'h16);
    chk("s3_count", 64'(last_c0), 64'd5);
    pat = {$urandom, $urandom};
    for (int i = 63; i >= 0; i--) step(1'b0, 1'b1, pat[i], 0, 0, 1'b1);
    idle(2, 1'b1);
    look();
    chk("s3_full", last_d0, pat);

    // 4: backpressure across two words
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 130; i++) step(1'b0, 1'b1, 1'($urandom), 0, 0, 1'b0);
    idle(1, 1'b0);
    look();
    chk("s4_ovf", 64'(o[0]), 64'd1);
    chk("s4_wcnt0", 64'(wc[0]), 64'd0);
    chk("s4_held", 64'(v[0]), 64'd1);
    idle(3, 1'b1);
    look();
    chk("s4_wcnt1", 64'(wc[0]), 64'd1);
    chk("s4_vfall", 64'(v[0]), 64'd0);
    chk("s4_sticky", 64'(o[0]), 64'd1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    idle(1, 1'b1);
    look();
    chk("s4_clr", 64'(o[0]), 64'd0);

    // 5: completion coincides with handshake of the held word
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'($urandom), 0, 0, 1'b0);
    for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 1'($urandom), 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'($urandom), 0, 0, 1'b1);
    idle(1, 1'b0);
    look();
    chk("s5_valid", 64'(v[0]), 64'd1);
    chk("s5_wcnt", 64'(wc[0]), 64'd1);
    chk("s5_ovf", 64'(o[0]), 64'd0);
    idle(3, 1'b1);
    look();
    chk("s5_wcnt2", 64'(wc[0]), 64'd2);

    // 6: reset mid-word with a held word
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 104; i++) step(1'b0, 1'b1, 1'($urandom), 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    idle(1, 1'b0);
    look();
    chk("s6_valid", 64'(v[0]), 64'd0);
    chk("s6_data", d[0], '0);
    chk("s6_count", 64'(c[0]), 64'd0);
    chk("s6_ovf", 64'(o[0]), 64'd0);
    chk("s6_wcnt", 64'(wc[0]), 64'd0);
    expw = '0;
    for (int i = 0; i < 64; i++) begin
      b = 1'($urandom);
      expw = {expw[62:0], b};
      step(1'b0, 1'b1, b, 0, 0, 1'b1);
    end
    idle(2, 1'b1);
    look();
    chk("s6_clean", last_d0, expw);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 2) != 0));
    idle(4, 1'b1);
    look();
    chk("drain_msb", 64'(q0.size()), 64'd0);
    chk("drain_lsb", 64'(q1.size()), 64'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
